audio_stream_ctrl: RTL and testbench
====================================

Name: audio_stream_ctrl

Overview:
- Sequences sample playback from the 8-bit audio sample FIFO to the PWM audio module.
- Paces FIFO reads at the sample rate.
- Issues block refill requests to the SD read path so the FIFO stays above a low-water mark.
- Handles prime, underrun, end-of-clip and stop, and outputs idle level 0x80 whenever it is not playing.

Parameters:
- SAMPLE_DIV, 2083, clk cycles per sample (100 MHz / 2083 ≈ 48 kHz).
- CNT_W, 11, width of the FIFO data_count input.
- LOW_WATER, 1024, FIFO occupancy below which a refill is requested.
- BLOCK_BYTES, 512, bytes delivered per refill; also the refill_addr increment.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- play  in  1  one-cycle pulse; starts playback from IDLE.
- stop  in  1  one-cycle pulse; aborts playback.
- start_addr  in  32  first SD byte address of the clip.
- end_addr  in  32  exclusive end address of the clip.
- fifo_count  in  CNT_W  FIFO data_count.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  8  FIFO read data; valid 1 cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe.
- refill_req  out  1  refill request level; held until refill_done.
- refill_addr  out  32  SD address of the requested block.
- refill_done  in  1  one-cycle pulse; block fully written to FIFO.
- sample_out  out  8  unsigned sample to audio_PWM.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- playing  out  1  high in PRIME, PLAY, UNDERRUN.
- clip_done  out  1  one-cycle pulse at natural end of clip.
- underrun_cnt  out  8  saturating underrun event counter.

Behaviour:
- Reset values (asynchronous, reset_n low):
  - state = IDLE; all pulses/strobes 0; refill_req = 0.
  - refill_addr = 0; sample_out = 8'h80; underrun_cnt = 0.
  - eof = 0; divider = 0.
- States: IDLE, PRIME, PLAY, UNDERRUN, ABORT.
- IDLE:
  - On play: refill_addr <= start_addr; eof <= (start_addr >= end_addr); underrun_cnt kept; go to PRIME.
  - play while not in IDLE is ignored.
- Refill engine (active in PRIME/PLAY/UNDERRUN):
  - Requests when refill_req == 0 and !eof and fifo_count < LOW_WATER: sets refill_req = 1 with refill_addr stable.
  - On refill_done: refill_req <= 0 (same edge); refill_addr <= refill_addr + BLOCK_BYTES.
  - eof <= 1 if the new address >= end_addr.
  - At most one request outstanding. refill_done while refill_req == 0 is ignored.
- PRIME:
  - Go to PLAY (divider cleared) when fifo_count >= LOW_WATER, or when eof and !fifo_empty.
  - If eof and fifo_empty: go to IDLE and pulse clip_done.
- PLAY:
  - divider counts 0..SAMPLE_DIV-1; tick when divider == SAMPLE_DIV-1.
  - At the tick cycle, if !fifo_empty: fifo_rd_en = 1 on the next cycle; sample_out <= fifo_dout and sample_valid = 1 on the cycle after that. Latency from tick to sample_out is 2 cycles.
  - At tick with fifo_empty and eof: go to IDLE, sample_out <= 8'h80, pulse clip_done.
  - At tick with fifo_empty and !eof: go to UNDERRUN, sample_out <= 8'h80, underrun_cnt increments (saturating at 255).
- UNDERRUN:
  - Return to PLAY (divider cleared) when fifo_count >= LOW_WATER, or when eof and !fifo_empty.
  - If eof and fifo_empty: go to IDLE and pulse clip_done.
- Stop:
  - Takes effect in any non-IDLE state and wins over play and over a simultaneous tick.
  - sample_out <= 8'h80 next cycle; no further fifo_rd_en.
  - If refill_req == 1: go to ABORT, hold refill_req until refill_done, then go to IDLE. refill_addr is not advanced in ABORT.
  - Otherwise go to IDLE directly.
  - No clip_done pulse on stop.
- fifo_rd_en is never asserted while fifo_empty is sampled high. Sample pacing stays exactly SAMPLE_DIV cycles while in PLAY.

Optional Feature:
- Macro: AUDIO_STREAM_CTRL_VOLUME_EN.
- When defined:
  - Adds input volume[2:0].
  - Every sample is attenuated about the midpoint: sample_out = 128 + ((fifo_dout - 128) >>> volume), computed signed 9-bit and registered in the same cycle as the plain load (latency unchanged).
  - volume is sampled when the FIFO data is loaded.
- When undefined: no volume port; sample_out = fifo_dout.

Test Plan:
- Bench parameters for all scenarios: SAMPLE_DIV=4, LOW_WATER=4, BLOCK_BYTES=4.
- Reset then idle -> sample_out=0x80, refill_req=0, playing=0, underrun_cnt=0.
- play with start_addr=0x100, end_addr=0x108; model FIFO answers refills with bytes 0x10..0x17 -> refill_addr shows 0x100 then 0x104; samples 0x10..0x17 are output one per 4 cycles, each 2 cycles after its tick; then clip_done pulses once and sample_out=0x80.
- During PLAY, model withholds the second refill_done until the FIFO empties -> UNDERRUN entered, underrun_cnt=1, sample_out=0x80; after refill_done brings fifo_count to 4, samples resume.
- stop asserted while refill_req=1 -> fifo_rd_en stays 0; refill_req holds until refill_done; then IDLE with refill_addr unchanged.
- play and stop in the same cycle while in PLAY -> stop wins; play pulse in PLAY -> ignored; force 256 underruns -> underrun_cnt stays at 255.
- With AUDIO_STREAM_CTRL_VOLUME_EN, volume=1, FIFO bytes 0xFF and 0x00 -> sample_out 0xBF and 0x40.

Source files
------------

// File: rtl/audio_stream_ctrl.sv
// rtl/audio_stream_ctrl.sv - paces FIFO samples to the PWM stage and keeps the FIFO refilled from SD; AUDIO_STREAM_CTRL_VOLUME_EN adds volume attenuation
module audio_stream_ctrl #(
  parameter int SAMPLE_DIV  = 2083,
  parameter int CNT_W       = 11,
  parameter int LOW_WATER   = 1024,
  parameter int BLOCK_BYTES = 512
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             play,
  input  logic             stop,
  input  logic [31:0]      start_addr,
  input  logic [31:0]      end_addr,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd_en,
  output logic             refill_req,
  output logic [31:0]      refill_addr,
  input  logic             refill_done,
  output logic [7:0]       sample_out,
  output logic             sample_valid,
  output logic             playing,
  output logic             clip_done,
  output logic [7:0]       underrun_cnt
`ifdef AUDIO_STREAM_CTRL_VOLUME_EN
  ,
  input  logic [2:0]       volume
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PRIME    = 3'd1;
  localparam logic [2:0] PLAY     = 3'd2;
  localparam logic [2:0] UNDERRUN = 3'd3;
  localparam logic [2:0] ABORT    = 3'd4;

  localparam int               DIV_W       = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] LOW_WATER_C = CNT_W'(LOW_WATER);
  localparam logic [31:0]      BLOCK_C     = 32'(BLOCK_BYTES);
  localparam logic [7:0]       MIDPOINT    = 8'h80;

  logic [2:0]       state;
  logic [DIV_W-1:0] divider;
  logic             eof;
  logic [31:0]      end_q;
  logic             load_q;
  logic [31:0]      next_addr;
  logic [7:0]       load_value;
  logic             tick;
  logic             resume_ok;
  logic             clip_end;

  assign next_addr = refill_addr + BLOCK_C;
  assign tick      = (divider == DIV_LAST);
  // PRIME and UNDERRUN share the same exit rules
  assign resume_ok = (fifo_count >= LOW_WATER_C) || (eof && !fifo_empty);
  assign clip_end  = eof && fifo_empty;
  assign playing   = (state == PRIME) || (state == PLAY) || (state == UNDERRUN);

`ifdef AUDIO_STREAM_CTRL_VOLUME_EN
  logic signed [8:0] centered;
  logic signed [8:0] scaled;

  // attenuate about the midpoint: shift the signed offset, then re-bias
  always_comb begin
    centered   = $signed({1'b0, fifo_dout}) - 9'sd128;
    scaled     = centered >>> volume;
    load_value = 8'(scaled + 9'sd128);
  end
`else
  // plain build passes FIFO bytes straight through
  always_comb begin
    load_value = fifo_dout;
  end
`endif

  // playback sequencer, sample pipeline and refill engine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      divider      <= '0;
      eof          <= 1'b0;
      end_q        <= '0;
      load_q       <= 1'b0;
      fifo_rd_en   <= 1'b0;
      refill_req   <= 1'b0;
      refill_addr  <= '0;
      sample_out   <= MIDPOINT;
      sample_valid <= 1'b0;
      clip_done    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      // read strobe and load flag form a two-stage pipeline behind each tick
      fifo_rd_en   <= 1'b0;
      load_q       <= fifo_rd_en;
      sample_valid <= 1'b0;
      clip_done    <= 1'b0;
      if (load_q) begin
        sample_out   <= load_value;
        sample_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (play) begin
            refill_addr <= start_addr;
            end_q       <= end_addr;
            eof         <= (start_addr >= end_addr);
            state       <= PRIME;
          end
        end

        ABORT: begin
          // the outstanding block is drained but its address is discarded
          if (refill_done) begin
            refill_req <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          if (stop) begin
            // stop overrides any pending tick, load or play
            sample_out   <= MIDPOINT;
            sample_valid <= 1'b0;
            fifo_rd_en   <= 1'b0;
            load_q       <= 1'b0;
            if (refill_req && !refill_done) begin
              state <= ABORT;
            end else begin
              refill_req <= 1'b0;
              state      <= IDLE;
            end
          end else begin
            if (refill_req) begin
              if (refill_done) begin
                refill_req  <= 1'b0;
                refill_addr <= next_addr;
                if (next_addr >= end_q) begin
                  eof <= 1'b1;
                end
              end
            end else if (!eof && (fifo_count < LOW_WATER_C)) begin
              refill_req <= 1'b1;
            end

            if (state == PLAY) begin
              if (tick) begin
                divider <= '0;
                if (!fifo_empty) begin
                  fifo_rd_en <= 1'b1;
                end else if (eof) begin
                  sample_out <= MIDPOINT;
                  clip_done  <= 1'b1;
                  state      <= IDLE;
                end else begin
                  sample_out <= MIDPOINT;
                  if (underrun_cnt != 8'hFF) begin
                    underrun_cnt <= underrun_cnt + 8'd1;
                  end
                  state <= UNDERRUN;
                end
              end else begin
                divider <= divider + 1'b1;
              end
            end else if (resume_ok) begin
              divider <= '0;
              state   <= PLAY;
            end else if (clip_end) begin
              clip_done <= 1'b1;
              state     <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// tb/tb_audio_stream_ctrl.sv - scoreboard bench for audio_stream_ctrl with a FIFO/SD model
module tb_audio_stream_ctrl;
  localparam int SAMPLE_DIV  = 4;
  localparam int CNT_W       = 11;
  localparam int LOW_WATER   = 4;
  localparam int BLOCK_BYTES = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             play = 1'b0;
  logic             stop = 1'b0;
  logic [31:0]      start_addr = '0;
  logic [31:0]      end_addr = '0;
  logic [CNT_W-1:0] fifo_count = '0;
  logic             fifo_empty = 1'b1;
  logic [7:0]       fifo_dout = '0;
  logic             fifo_rd_en;
  logic             refill_req;
  logic [31:0]      refill_addr;
  logic             refill_done = 1'b0;
  logic [7:0]       sample_out;
  logic             sample_valid;
  logic             playing;
  logic             clip_done;
  logic [7:0]       underrun_cnt;
`ifdef AUDIO_STREAM_CTRL_VOLUME_EN
  logic [2:0]       volume = 3'd0;
`endif

  audio_stream_ctrl #(
    .SAMPLE_DIV(SAMPLE_DIV), .CNT_W(CNT_W), .LOW_WATER(LOW_WATER), .BLOCK_BYTES(BLOCK_BYTES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .play(play), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .refill_req(refill_req), .refill_addr(refill_addr),
    .refill_done(refill_done), .sample_out(sample_out), .sample_valid(sample_valid),
    .playing(playing), .clip_done(clip_done), .underrun_cnt(underrun_cnt)
`ifdef AUDIO_STREAM_CTRL_VOLUME_EN
    , .volume(volume)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // FIFO + SD read path model, updated on the falling edge
  logic [7:0] fifo_q[$];
  logic [7:0] src_q[$];
  int resp_mode = 0;
  int req_age = 0;
  int empty_run = 0;
  bit flush_req = 1'b0;

  always @(negedge clk) begin
    refill_done = 1'b0;
    if (fifo_rd_en && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    empty_run = (fifo_q.size() == 0) ? empty_run + 1 : 0;
    req_age = refill_req ? req_age + 1 : 0;
    if (refill_req && ((resp_mode == 0 && req_age >= 3) || (resp_mode == 2 && empty_run >= 6))) begin
      for (int i = 0; i < BLOCK_BYTES; i++)
        fifo_q.push_back((src_q.size() > 0) ? src_q.pop_front() : 8'h00);
      refill_done = 1'b1;
      req_age = 0;
    end
    if (flush_req) begin
      fifo_q.delete();
      flush_req = 1'b0;
    end
    fifo_count = CNT_W'(fifo_q.size());
    fifo_empty = (fifo_q.size() == 0);
  end

  // monitor: scoreboard, read-strobe rules and event logging
  logic [7:0]  exp_q[$];
  logic [31:0] addr_log[$];
  bit sb_en = 1'b1;
  bit pace_en = 1'b0;
  bit req_prev = 1'b0;
  int cyc = 0;
  int last_rd_cyc = -1;
  int rd_events = 0;
  int clip_cnt = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sample_valid) begin
      check("rd_to_sample_latency", cyc - last_rd_cyc, 2);
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sample_unexpected: got 0x%0h, expected no sample", sample_out);
        end else begin
          check("sample", sample_out, exp_q.pop_front());
        end
      end
    end
    if (fifo_rd_en) begin
      check("rd_while_empty", fifo_empty, 0);
      if (pace_en && last_rd_cyc >= 0) check("sample_pace", cyc - last_rd_cyc, SAMPLE_DIV);
      last_rd_cyc = cyc;
      rd_events++;
    end
    if (refill_req && !req_prev) addr_log.push_back(refill_addr);
    req_prev = refill_req;
    if (clip_done) clip_cnt++;
  end

  task automatic pulse_play();
    @(negedge clk) play = 1'b1;
    @(negedge clk) play = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic wait_clip(input int base, input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (clip_cnt > base) return;
    end
    fail_timeout(name);
  endtask

  task automatic wait_addr(input logic [31:0] a, input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (refill_addr == a) return;
    end
    fail_timeout(name);
  endtask

  task automatic wait_sample(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_valid) return;
    end
    fail_timeout(name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!playing && !refill_req) return;
    end
    fail_timeout(name);
  endtask

  task automatic wait_underruns(input logic [7:0] v, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (underrun_cnt == v) return;
    end
    fail_timeout(name);
  endtask

  task automatic load_clip(input logic [7:0] first, input int n, input bit expect_all);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(first + 8'(i));
      if (expect_all) exp_q.push_back(first + 8'(i));
    end
  endtask

  task automatic cleanup();
    repeat (2) @(negedge clk);
    flush_req = 1'b1;
    src_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  int base;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_sample_out", sample_out, 8'h80);
    check("rst_refill_req", refill_req, 0);
    check("rst_playing", playing, 0);
    check("rst_underrun_cnt", underrun_cnt, 0);
    check("rst_refill_addr", refill_addr, 0);
    check("rst_fifo_rd_en", fifo_rd_en, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_sample_out", sample_out, 8'h80);
    check("idle_refill_req", refill_req, 0);

    // full clip of two blocks
    load_clip(8'h10, 8, 1'b1);
    addr_log.delete();
    base = clip_cnt;
    last_rd_cyc = -1;
    pace_en = 1'b1;
    start_addr = 32'h100;
    end_addr = 32'h108;
    pulse_play();
    wait_clip(base, "clip1_done");
    pace_en = 1'b0;
    repeat (3) @(negedge clk);
    check("clip1_done_count", clip_cnt - base, 1);
    check("clip1_idle_level", sample_out, 8'h80);
    check("clip1_playing", playing, 0);
    check("clip1_req_count", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check("clip1_addr0", addr_log[0], 32'h100);
      check("clip1_addr1", addr_log[1], 32'h104);
    end
    check("clip1_final_addr", refill_addr, 32'h108);
    check("clip1_sb_drained", exp_q.size(), 0);

    // underrun when the second block is withheld
    load_clip(8'h20, 12, 1'b1);
    base = clip_cnt;
    resp_mode = 0;
    start_addr = 32'h200;
    end_addr = 32'h20C;
    pulse_play();
    wait_addr(32'h204, "ur_first_block");
    resp_mode = 1;
    wait_underruns(8'd1, 300, "ur_enter");
    check("ur_count", underrun_cnt, 1);
    check("ur_idle_level", sample_out, 8'h80);
    check("ur_playing", playing, 1);
    check("ur_refill_req", refill_req, 1);
    resp_mode = 0;
    wait_clip(base, "ur_clip_done");
    repeat (3) @(negedge clk);
    check("ur_sb_drained", exp_q.size(), 0);
    check("ur_count_after", underrun_cnt, 1);
    check("ur_final_addr", refill_addr, 32'h20C);

    // stop while a refill is outstanding
    load_clip(8'h30, 12, 1'b0);
    exp_q.push_back(8'h30);
    resp_mode = 0;
    start_addr = 32'h300;
    end_addr = 32'h400;
    pulse_play();
    wait_addr(32'h304, "stop_first_block");
    resp_mode = 1;
    wait_sample("stop_first_sample");
    check("stop_req_before", refill_req, 1);
    base = rd_events;
    pulse_stop();
    check("stop_idle_level", sample_out, 8'h80);
    check("stop_playing", playing, 0);
    repeat (12) @(negedge clk);
    check("stop_no_reads", rd_events - base, 0);
    check("stop_req_held", refill_req, 1);
    resp_mode = 0;
    wait_idle("stop_abort_exit");
    check("stop_addr_kept", refill_addr, 32'h304);
    check("stop_sb_drained", exp_q.size(), 0);
    cleanup();

    // play ignored in PLAY; play and stop together -> stop wins
    load_clip(8'h40, 16, 1'b1);
    start_addr = 32'h400;
    end_addr = 32'h500;
    pulse_play();
    wait_sample("ps_first_sample");
    start_addr = 32'h900;
    pulse_play();
    repeat (2) @(negedge clk);
    check("ps_play_ignored_playing", playing, 1);
    check("ps_play_ignored_addr", {8'h00, refill_addr[31:8]}, 32'h4);
    @(negedge clk);
    play = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    play = 1'b0;
    stop = 1'b0;
    check("ps_stop_wins", playing, 0);
    wait_idle("ps_idle");
    repeat (4) @(negedge clk);
    check("ps_stays_idle", playing, 0);
    check("ps_no_reload", {8'h00, refill_addr[31:8]}, 32'h4);
    cleanup();

    // empty clip: start == end ends immediately
    base = clip_cnt;
    start_addr = 32'h600;
    end_addr = 32'h600;
    pulse_play();
    repeat (4) @(negedge clk);
    check("empty_clip_done", clip_cnt - base, 1);
    check("empty_clip_playing", playing, 0);
    check("empty_clip_no_req", refill_req, 0);

    // underrun counter saturation
    sb_en = 1'b0;
    resp_mode = 2;
    start_addr = 32'h1000;
    end_addr = 32'h1000_0000;
    pulse_play();
    wait_underruns(8'd255, 20000, "sat_reach");
    repeat (100) @(negedge clk);
    check("sat_count", underrun_cnt, 8'hFF);
    check("sat_playing", playing, 1);
    resp_mode = 0;
    pulse_stop();
    wait_idle("sat_idle");
    check("sat_idle_level", sample_out, 8'h80);
    cleanup();
    sb_en = 1'b1;

`ifdef AUDIO_STREAM_CTRL_VOLUME_EN
    // volume attenuation about the midpoint
    volume = 3'd1;
    src_q.push_back(8'hFF); src_q.push_back(8'h00);
    src_q.push_back(8'hFF); src_q.push_back(8'h00);
    exp_q.push_back(8'hBF); exp_q.push_back(8'h40);
    exp_q.push_back(8'hBF); exp_q.push_back(8'h40);
    base = clip_cnt;
    start_addr = 32'h2000;
    end_addr = 32'h2004;
    pulse_play();
    wait_clip(base, "vol_clip_done");
    repeat (3) @(negedge clk);
    check("vol_sb_drained", exp_q.size(), 0);
    check("vol_idle_level", sample_out, 8'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
